// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-stage controller and MEM/WB pipeline register for the five-stage
// WISC-SP20 core. Loads and stores held in EX/MEM are issued to a multi-cycle,
// stall-capable data memory. The whole pipeline is frozen while an access is
// outstanding. Non-memory instructions pass straight into MEM/WB in one cycle.
//
// Parameters
//   TIMEOUT    cycles an access may stay outstanding (REQ + WAIT) before it is
//              abandoned and err sets; legal range 2..255.
//   NOP_INSTR  bubble instruction loaded into MEM/WB (opcode 00001, nop).
//
// Ports
//   clk, rst                 core clock; asynchronous active-high reset
//   valid_e .. store_data    EX/MEM latch contents (stable while stall_pipe=1)
//   mem_en, mem_wr           data-memory request strobe / write select
//   mem_addr, mem_wdata      request address / write data (driven in REQ only)
//   mem_rdata, mem_stall,
//   mem_done                 memory read data, busy, and completion pulse
//   stall_pipe               freezes PC, IF/ID, ID/EX and EX/MEM
//   memory_read_data ..
//   mem_read_mem             MEM/WB register consumed by writeback/forwarding
//   err                      sticky: unaligned access or timeout
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_e,
  input  logic [15:0] instruction_e,
  input  logic [2:0]  rd_e,
  input  logic [2:0]  rs_e,
  input  logic        valid_rd_e,
  input  logic        reg_write_ex,
  input  logic        mem_read_ex,
  input  logic        mem_write_ex,
  input  logic [15:0] execute_data,
  input  logic [15:0] store_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_done,
  output logic        stall_pipe,
  output logic [15:0] memory_read_data,
  output logic [15:0] mem_address,
  output logic [15:0] instruction_m,
  output logic [2:0]  rd_m,
  output logic [2:0]  rs_m,
  output logic        valid_rd_m,
  output logic        reg_write_mem,
  output logic        mem_read_mem,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Count value at which an outstanding access is declared dead.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] cnt;

  logic mem_op;
  logic timeout_hit;
  logic load_live;     // MEM/WB takes the EX/MEM contents
  logic load_bubble;   // MEM/WB takes a nop, data fields hold
  logic capture_rdata; // completion of a load: keep the returned data
  logic err_set;
  logic cnt_clear;
  logic cnt_inc;

  assign mem_op      = mem_read_ex | mem_write_ex;
  assign timeout_hit = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next    = state;
    stall_pipe    = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    load_live     = 1'b0;
    load_bubble   = 1'b0;
    capture_rdata = 1'b0;
    err_set       = 1'b0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!valid_e) begin
          load_bubble = 1'b1;
        end else if (!mem_op) begin
          load_live = 1'b1;
        end else if (execute_data[0]) begin
          // Unaligned word access: never reaches the memory.
          err_set     = 1'b1;
          load_bubble = 1'b1;
        end else begin
          // Stall starts in the decode cycle so EX/MEM stays put for REQ.
          stall_pipe = 1'b1;
          cnt_clear  = 1'b1;
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        mem_en    = 1'b1;
        mem_wr    = mem_write_ex;
        mem_addr  = execute_data;
        mem_wdata = store_data;
        cnt_inc   = 1'b1;
        if (timeout_hit) begin
          err_set     = 1'b1;
          load_bubble = 1'b1;
          state_next  = S_IDLE;
        end else begin
          stall_pipe = 1'b1;
          if (!mem_stall) state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_inc = 1'b1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (mem_done) begin
          load_live     = 1'b1;
          capture_rdata = mem_read_ex;
          state_next    = S_IDLE;
        end else if (timeout_hit) begin
          err_set     = 1'b1;
          load_bubble = 1'b1;
          state_next  = S_IDLE;
        end else begin
          stall_pipe = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state, timeout counter and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of block ordering.
      state <= state_next;
      if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_inc && (cnt != 8'hFF)) begin
        cnt <= cnt + 8'd1;
      end
      if (err_set) err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memory_read_data <= '0;
      mem_address      <= '0;
      instruction_m    <= NOP_INSTR;
      rd_m             <= '0;
      rs_m             <= '0;
      valid_rd_m       <= 1'b0;
      reg_write_mem    <= 1'b0;
      mem_read_mem     <= 1'b0;
    end else if (load_live) begin
      if (capture_rdata) memory_read_data <= mem_rdata;
      mem_address   <= execute_data;
      instruction_m <= instruction_e;
      rd_m          <= rd_e;
      rs_m          <= rs_e;
      valid_rd_m    <= valid_rd_e;
      reg_write_mem <= reg_write_ex;
      mem_read_mem  <= mem_read_ex;
    end else if (load_bubble) begin
      // A nop rather than all-zeros keeps downstream decode from seeing halt.
      instruction_m <= NOP_INSTR;
      valid_rd_m    <= 1'b0;
      reg_write_mem <= 1'b0;
      mem_read_mem  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. The driver issues EX/MEM contents and memory
// responses cycle by cycle and pushes the MEM/WB contents it expects into a
// queue for every cycle in which the pipeline is not stalled. A monitor pops
// and compares after each edge that follows an unstalled cycle. A second
// instance with TIMEOUT=4 covers the timeout boundaries.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic        vrd;
    logic        rw;
    logic        mr;
  } mwb_t;

  localparam mwb_t RESET_MWB = '{rdata: 16'h0, addr: 16'h0, instr: NOP,
                                 rd: 3'd0, rs: 3'd0, vrd: 1'b0, rw: 1'b0, mr: 1'b0};

  logic        clk = 1'b0;
  logic        rst, rst_to;
  logic        valid_e;
  logic [15:0] instruction_e;
  logic [2:0]  rd_e, rs_e;
  logic        valid_rd_e, reg_write_ex, mem_read_ex, mem_write_ex;
  logic [15:0] execute_data, store_data;
  logic [15:0] mem_rdata;
  logic        mem_stall, mem_done, mem_done_to;
  logic        no_stall = 1'b0;

  // Main instance outputs
  logic        mem_en, mem_wr, stall_pipe, err;
  logic [15:0] mem_addr, mem_wdata, memory_read_data, mem_address, instruction_m;
  logic [2:0]  rd_m, rs_m;
  logic        valid_rd_m, reg_write_mem, mem_read_mem;

  // TIMEOUT=4 instance outputs
  logic        mem_en_t, mem_wr_t, stall_pipe_t, err_t;
  logic [15:0] mem_addr_t, mem_wdata_t, memory_read_data_t, mem_address_t, instruction_m_t;
  logic [2:0]  rd_m_t, rs_m_t;
  logic        valid_rd_m_t, reg_write_mem_t, mem_read_mem_t;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .instruction_e(instruction_e),
    .rd_e(rd_e), .rs_e(rs_e), .valid_rd_e(valid_rd_e), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .execute_data(execute_data), .store_data(store_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
    .stall_pipe(stall_pipe), .memory_read_data(memory_read_data),
    .mem_address(mem_address), .instruction_m(instruction_m), .rd_m(rd_m), .rs_m(rs_m),
    .valid_rd_m(valid_rd_m), .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem),
    .err(err)
  );

  mem_stage #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst_to), .valid_e(valid_e), .instruction_e(instruction_e),
    .rd_e(rd_e), .rs_e(rs_e), .valid_rd_e(valid_rd_e), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .execute_data(execute_data), .store_data(store_data),
    .mem_en(mem_en_t), .mem_wr(mem_wr_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
    .mem_rdata(mem_rdata), .mem_stall(no_stall), .mem_done(mem_done_to),
    .stall_pipe(stall_pipe_t), .memory_read_data(memory_read_data_t),
    .mem_address(mem_address_t), .instruction_m(instruction_m_t), .rd_m(rd_m_t),
    .rs_m(rs_m_t), .valid_rd_m(valid_rd_m_t), .reg_write_mem(reg_write_mem_t),
    .mem_read_mem(mem_read_mem_t), .err(err_t)
  );

  int   errors = 0;
  int   checks = 0;
  mwb_t exp_q[$];
  mwb_t exp_mwb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_bubble();
    exp_mwb.instr = NOP;
    exp_mwb.vrd   = 1'b0;
    exp_mwb.rw    = 1'b0;
    exp_mwb.mr    = 1'b0;
    exp_q.push_back(exp_mwb);
  endtask

  task automatic set_ex(input logic [15:0] instr, input logic [2:0] rd, input logic [2:0] rs,
                        input logic vrd, input logic rw, input logic mr, input logic mw,
                        input logic [15:0] addr, input logic [15:0] sdata);
    valid_e       = 1'b1;
    instruction_e = instr;
    rd_e          = rd;
    rs_e          = rs;
    valid_rd_e    = vrd;
    reg_write_ex  = rw;
    mem_read_ex   = mr;
    mem_write_ex  = mw;
    execute_data  = addr;
    store_data    = sdata;
  endtask

  // One cycle with no live instruction; push=1 when the main instance is out
  // of reset and therefore loads a bubble at the coming edge.
  task automatic idle_cycle(input bit push);
    @(negedge clk);
    valid_e      = 1'b0;
    mem_read_ex  = 1'b0;
    mem_write_ex = 1'b0;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    mem_done_to  = 1'b0;
    if (push) push_bubble();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_stall_pipe"}, stall_pipe, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_memory_read_data"}, memory_read_data, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_instruction_m"}, instruction_m, NOP);
    check({tag, "_rd_rs"}, {rd_m, rs_m}, 0);
    check({tag, "_ctrl"}, {valid_rd_m, reg_write_mem, mem_read_mem}, 0);
  endtask

  // Monitor: an edge that ends an unstalled, out-of-reset cycle loads MEM/WB.
  initial begin : monitor
    logic pend;
    mwb_t e;
    forever begin
      @(negedge clk);
      #2;
      pend = !rst && !stall_pipe;
      @(posedge clk);
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("mwb_unexpected_load", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mwb_memory_read_data", memory_read_data, e.rdata);
          check("mwb_mem_address", mem_address, e.addr);
          check("mwb_instruction_m", instruction_m, e.instr);
          check("mwb_rd_m", rd_m, e.rd);
          check("mwb_rs_m", rs_m, e.rs);
          check("mwb_valid_rd_m", valid_rd_m, e.vrd);
          check("mwb_reg_write_mem", reg_write_mem, e.rw);
          check("mwb_mem_read_mem", mem_read_mem, e.mr);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : driver
    int stall_cycles, en_cycles, en_match;
    rst = 1'b1; rst_to = 1'b1;
    valid_e = 1'b0; instruction_e = '0; rd_e = '0; rs_e = '0;
    valid_rd_e = 1'b0; reg_write_ex = 1'b0; mem_read_ex = 1'b0; mem_write_ex = 1'b0;
    execute_data = '0; store_data = '0; mem_rdata = '0;
    mem_stall = 1'b0; mem_done = 1'b0; mem_done_to = 1'b0;
    exp_mwb = RESET_MWB;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    push_bubble();
    idle_cycle(1);

    // add r1 = r2 + r3, ALU result 0x1234: one-cycle pass-through
    @(negedge clk);
    set_ex(16'hDA64, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    exp_mwb = '{rdata: 16'h0, addr: 16'h1234, instr: 16'hDA64, rd: 3'd1, rs: 3'd2,
                vrd: 1'b1, rw: 1'b1, mr: 1'b0};
    exp_q.push_back(exp_mwb);
    #1;
    check("add_stall_pipe", stall_pipe, 0);
    check("add_mem_en", mem_en, 0);
    idle_cycle(1);
    #1;
    check("add_mem_address", mem_address, 16'h1234);
    check("add_reg_write_mem", reg_write_mem, 1);

    // Load from 0x0010; mem_done after two empty WAIT cycles
    stall_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) set_ex(16'h8C70, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
      mem_done  = (c == 4);
      mem_rdata = (c == 4) ? 16'hBEEF : 16'h5555;
      if (c == 4) begin
        exp_mwb = '{rdata: 16'hBEEF, addr: 16'h0010, instr: 16'h8C70, rd: 3'd3, rs: 3'd4,
                    vrd: 1'b1, rw: 1'b1, mr: 1'b1};
        exp_q.push_back(exp_mwb);
      end
      #1;
      if (stall_pipe) stall_cycles++;
      if (c == 1) begin
        check("load_req_mem_en", mem_en, 1);
        check("load_req_mem_wr", mem_wr, 0);
        check("load_req_mem_addr", mem_addr, 16'h0010);
      end
      if (c == 3) check("load_no_early_update", instruction_m, NOP);
    end
    check("load_stall_cycles", stall_cycles, 4);
    idle_cycle(1);
    #1;
    check("load_memory_read_data", memory_read_data, 16'hBEEF);
    check("load_mem_read_mem", mem_read_mem, 1);

    // Store to 0x0020 with the memory busy for three REQ cycles
    en_cycles = 0;
    en_match  = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) set_ex(16'h86A0, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hA5A5);
      mem_stall = (c >= 1 && c <= 3);
      mem_done  = (c == 6);
      mem_rdata = 16'h1111;
      if (c == 6) begin
        exp_mwb = '{rdata: 16'hBEEF, addr: 16'h0020, instr: 16'h86A0, rd: 3'd5, rs: 3'd6,
                    vrd: 1'b0, rw: 1'b0, mr: 1'b0};
        exp_q.push_back(exp_mwb);
      end
      #1;
      if (mem_en) begin
        en_cycles++;
        if (mem_addr == 16'h0020 && mem_wdata == 16'hA5A5 && mem_wr) en_match++;
      end
      if (c == 5) check("store_no_early_update", mem_address, 16'h0010);
    end
    check("store_mem_en_cycles", en_cycles, 4);
    check("store_req_stable", en_match, 4);
    idle_cycle(1);
    #1;
    check("store_mem_read_mem", mem_read_mem, 0);
    check("store_rdata_held", memory_read_data, 16'hBEEF);
    check("store_mem_address", mem_address, 16'h0020);

    // Unaligned load from 0x0011
    check("unal_err_before", err, 0);
    @(negedge clk);
    set_ex(16'h8C70, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    push_bubble();
    #1;
    check("unal_stall_pipe", stall_pipe, 0);
    check("unal_mem_en", mem_en, 0);
    idle_cycle(1);
    #1;
    check("unal_err", err, 1);
    check("unal_instruction_m", instruction_m, NOP);
    check("unal_reg_write_mem", reg_write_mem, 0);

    // Reset while waiting on a load, then a late mem_done
    @(negedge clk);
    set_ex(16'h8C70, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstw_in_wait_stall", stall_pipe, 1);
    check("rstw_in_wait_mem_en", mem_en, 0);
    rst = 1'b1;
    valid_e = 1'b0;
    mem_read_ex = 1'b0;
    exp_mwb = RESET_MWB;
    #2 check_reset("rstw");
    @(negedge clk);
    rst = 1'b0;
    mem_done  = 1'b1;
    mem_rdata = 16'hDEAD;
    push_bubble();
    idle_cycle(1);
    #1;
    check("late_done_rdata", memory_read_data, 16'h0000);
    check("late_done_err", err, 0);
    idle_cycle(1);
    @(negedge clk);
    rst = 1'b1;
    #3 check("scoreboard_drained", exp_q.size(), 0);

    // TIMEOUT=4 instance: done in the last allowed cycle, then a real timeout
    @(negedge clk);
    rst_to = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) set_ex(16'h8C70, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000);
      mem_done_to = (c == 4);
      mem_rdata   = (c == 4) ? 16'hCAFE : 16'h5555;
      #1;
      if (c == 1) check("to_req_mem_en", mem_en_t, 1);
      if (c == 4) check("to_done_stall", stall_pipe_t, 0);
    end
    idle_cycle(0);
    #1;
    check("to_done_err", err_t, 0);
    check("to_done_rdata", memory_read_data_t, 16'hCAFE);
    check("to_done_mem_read_mem", mem_read_mem_t, 1);

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) set_ex(16'h8C70, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0060, 16'h0000);
      mem_done_to = 1'b0;
      #1;
      if (c == 4) begin
        check("to_err_before", err_t, 0);
        check("to_wait_mem_en", mem_en_t, 0);
      end
    end
    idle_cycle(0);
    #1;
    check("to_err", err_t, 1);
    check("to_bubble_instr", instruction_m_t, NOP);
    check("to_bubble_reg_write", reg_write_mem_t, 0);
    check("to_rdata_held", memory_read_data_t, 16'hCAFE);
    @(negedge clk);
    set_ex(16'hDA64, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0000);
    #1 check("to_idle_stall", stall_pipe_t, 0);
    idle_cycle(0);
    #1 check("to_idle_accept", mem_address_t, 16'h0ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
